// File: rtl/font_blitter.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from ROM into a frame buffer at (spr_x, spr_y),
// skipping transparent (KEY) pixels and pixels that fall off the right or bottom of the screen.
module font_blitter #(
    parameter int SPR_W      = 30,
    parameter int SPR_H      = 30,
    parameter int SCR_W      = 640,
    parameter int SCR_H      = 480,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] KEY = 8'h2b
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [9:0]            spr_x,
    input  logic [9:0]            spr_y,
    output logic [9:0]            rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  fb_we,
    output logic [18:0]           fb_addr,
    output logic [DATA_WIDTH-1:0] fb_data,
    input  logic                  fb_ready,
    output logic                  busy,
    output logic                  done,
    output logic [9:0]            wr_count
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    localparam logic [10:0]   SCR_W11  = 11'(SCR_W);
    localparam logic [10:0]   SCR_H11  = 11'(SCR_H);
    localparam logic [18:0]   SCR_W19  = 19'(SCR_W);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t                state_reg, state_next;
    logic [9:0]            x0_reg, y0_reg;
    logic [CW-1:0]         col_reg;
    logic [RW-1:0]         row_reg;
    logic [9:0]            rom_addr_reg;
    logic [18:0]           fb_addr_reg;
    logic [DATA_WIDTH-1:0] pixel_reg;
    logic                  write_reg;
    logic [9:0]            wr_count_reg;

    logic        last_pixel;
    logic        advance;
    logic [10:0] scr_x, scr_y;
    logic        visible;

    // Screen coordinates are 11 bits wide so a sprite near the 10-bit limit cannot wrap back on screen.
    assign scr_x      = {1'b0, x0_reg} + 11'(col_reg);
    assign scr_y      = {1'b0, y0_reg} + 11'(row_reg);
    assign visible    = (scr_x < SCR_W11) && (scr_y < SCR_H11);
    assign last_pixel = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        fb_we      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                fb_we = write_reg;
                // Skipped pixels advance at once; written pixels wait for the frame buffer.
                if (!write_reg || fb_ready) begin
                    advance    = 1'b1;
                    state_next = last_pixel ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x0_reg       <= '0;
            y0_reg       <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            rom_addr_reg <= '0;
            fb_addr_reg  <= '0;
            pixel_reg    <= '0;
            write_reg    <= 1'b0;
            wr_count_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                x0_reg       <= spr_x;
                y0_reg       <= spr_y;
                col_reg      <= '0;
                row_reg      <= '0;
                rom_addr_reg <= '0;
                wr_count_reg <= '0;
            end
            if (state_reg == FETCH) begin
                pixel_reg   <= rom_data;
                fb_addr_reg <= 19'(scr_y) * SCR_W19 + 19'(scr_x);
                write_reg   <= (rom_data != KEY) && visible;
            end
            if (fb_we && fb_ready) begin
                wr_count_reg <= wr_count_reg + 10'd1;
            end
            // rom_addr is linear in (row, col), so stepping to the next pixel is a plain increment.
            if (advance && !last_pixel) begin
                rom_addr_reg <= rom_addr_reg + 10'd1;
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
        end
    end

    assign rom_addr = rom_addr_reg;
    assign fb_addr  = fb_addr_reg;
    assign fb_data  = pixel_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: doc/font_blitter.md
FONT_BLITTER -- requirements
Module: font_blitter

Interface
REQ-001 Parameter SPR_W, default 30, sprite width in pixels.
REQ-002 Parameter SPR_H, default 30, sprite height in pixels; sprite ROM depth is SPR_W*SPR_H = 900.
REQ-003 Parameter SCR_W, default 640, frame buffer width in pixels.
REQ-004 Parameter SCR_H, default 480, frame buffer height in pixels.
REQ-005 Parameter DATA_WIDTH, default 8, palette index width.
REQ-006 Parameter KEY, default 8'h2b, transparent palette index; pixels equal to KEY are never written.
REQ-007 Clk  input  1  single clock; all state updates on its rising edge.
REQ-008 Reset_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  request a blit; sampled only in IDLE.
REQ-010 spr_x  input  10  screen column of the sprite top-left corner, unsigned; latched on accepted start.
REQ-011 spr_y  input  10  screen row of the sprite top-left corner, unsigned; latched on accepted start.
REQ-012 rom_addr  output  10  sprite ROM address, row*SPR_W+col.
REQ-013 rom_data  input  DATA_WIDTH  sprite ROM data; combinational, valid in the same cycle as rom_addr.
REQ-014 fb_we  output  1  frame buffer write request.
REQ-015 fb_addr  output  19  frame buffer address, (spr_y+row)*SCR_W + (spr_x+col).
REQ-016 fb_data  output  DATA_WIDTH  frame buffer write data.
REQ-017 fb_ready  input  1  frame buffer accepts the write on a rising edge where fb_we=1 and fb_ready=1.
REQ-018 busy  output  1  high in FETCH and WRITE.
REQ-019 done  output  1  one-cycle pulse in DONE.
REQ-020 wr_count  output  10  pixels actually written in the current or last blit.

Function
REQ-021 States: IDLE, FETCH, WRITE, DONE; registered col/row counters hold the current pixel.
REQ-022 IDLE: start=1 latches spr_x/spr_y, clears col, row and wr_count, and moves to FETCH; start=0 stays in IDLE.
REQ-023 FETCH (1 cycle): rom_addr=row*SPR_W+col; rom_data is captured into a pixel register; screen x/y are computed at 11-bit width to avoid overflow; next state is WRITE.
REQ-024 WRITE, skip case: pixel==KEY, or x>=SCR_W, or y>=SCR_H; fb_we=0 and advance in 1 cycle.
REQ-025 WRITE, write case: fb_we=1 with fb_addr/fb_data stable until the accepting edge; on acceptance, wr_count increments and the block advances.
REQ-026 While fb_ready=0 in the write case, fb_we, fb_addr and fb_data hold unchanged; there is no timeout.
REQ-027 Advance: col+1; at col=SPR_W-1, col wraps to 0 and row increments; if the finished pixel was row=SPR_H-1, col=SPR_W-1, go to DONE, otherwise go to FETCH.
REQ-028 DONE (1 cycle): done=1, busy=0, then IDLE; wr_count holds until the next accepted start.
REQ-029 start is ignored in FETCH, WRITE and DONE; no queuing.
REQ-030 Latency with fb_ready tied high: 2 cycles per pixel; done is asserted in the 1801st cycle after the start edge, for any mix of written and skipped pixels.
REQ-031 Every fb_addr issued is <= SCR_W*SCR_H-1 = 307199; no write is issued for a clipped pixel.
REQ-032 fb_we=0 outside the WRITE write case; rom_addr is don't-care-stable (holds last value) outside FETCH.

Reset
REQ-033 Reset_n=0 immediately forces IDLE; fb_we, busy, done = 0; rom_addr, fb_addr, fb_data, wr_count, col, row = 0.
REQ-034 Reset mid-blit abandons it; no further write is issued after reset asserts, and the first start after release begins a fresh blit.

Verification
REQ-035 Reset: assert Reset_n=0 mid-cycle -> all outputs 0 without waiting for a Clk edge.
REQ-036 ROM model all 8'h05, spr=(0,0), fb_ready=1 -> 900 writes; first write fb_addr=0, fb_data=8'h05; last write fb_addr=18589; done in cycle 1801; wr_count=900.
REQ-037 ROM model all 8'h2b -> zero fb_we pulses; done in cycle 1801; wr_count=0.
REQ-038 Opaque ROM, spr=(620,470) -> 200 writes (cols 0-19, rows 0-9); last fb_addr=307199; no address >307199; done in cycle 1801.
REQ-039 Opaque ROM, fb_ready=0 for 3 cycles on the first write -> fb_we/fb_addr/fb_data stable for 4 cycles; done in cycle 1804; start pulsed while busy -> ignored.
REQ-040 Reset_n pulsed after the 100th write -> no writes afterward; a new start at (10,10) -> first fb_addr=6410; 900 writes; wr_count=900.
